// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V sequencing controller (ADD/SUB/AND/OR/SLT/ADDI/LB/SB/BEQ).
// Define ILLEGAL_TRAP_EN to trap on illegal decode; otherwise illegal ops retire as NOPs.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       OP,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ULAControl,
    output logic [CNT_W-1:0] InstRet,
    output logic             Illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = TRAP;
`else
    localparam state_t ILL_NEXT = FETCH;
`endif

    state_t     state_q;
    state_t     state_d;
    logic       retire_c;
    logic       r_legal_c;
    logic [2:0] r_ula_c;
    logic [1:0] imm_sel_c;

    // R-type {Funct3,Funct7} decode
    always_comb begin
        r_legal_c = 1'b1;
        r_ula_c   = ALU_ADD;
        case ({Funct3, Funct7})
            10'b000_0000000: r_ula_c = ALU_ADD;
            10'b000_0100000: r_ula_c = ALU_SUB;
            10'b111_0000000: r_ula_c = ALU_AND;
            10'b110_0000000: r_ula_c = ALU_OR;
            10'b010_0000000: r_ula_c = ALU_SLT;
            default:         r_legal_c = 1'b0;
        endcase
    end

    always_comb begin
        case (OP)
            OP_STORE:  imm_sel_c = 2'b01;
            OP_BRANCH: imm_sel_c = 2'b10;
            default:   imm_sel_c = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next state and per-state control decode
    always_comb begin
        state_d    = state_q;
        retire_c   = 1'b0;
        MemReq     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ULAControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel_c;
                if ((OP == OP_LOAD || OP == OP_STORE) && Funct3 == 3'b000) state_d = MEMADR;
                else if (OP == OP_RTYPE && r_legal_c)                      state_d = EXECUTER;
                else if (OP == OP_ITYPE && Funct3 == 3'b000)               state_d = EXECUTEI;
                else if (OP == OP_BRANCH && Funct3 == 3'b000)              state_d = BRANCH;
                else                                                       state_d = ILL_NEXT;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel_c;
                state_d = (OP == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire_c  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = MemReady;
                if (MemReady) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ULAControl = r_ula_c;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ULAControl = ALU_SUB;
                PCWrite    = Zero;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
        // State sits at FETCH during reset; keep its memory request and strobes quiet
        if (!rst_n) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            retire_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        InstRet <= '0;
        else if (retire_c) InstRet <= InstRet + CNT_W'(1);
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                Illegal <= 1'b0;
        else if (state_d == TRAP)  Illegal <= 1'b1;
    end
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle RISC-V datapath that shares one ALU and one unified instruction/data memory port across the steps of each instruction.
- Supports ADD, SUB, AND, OR, SLT, ADDI, LB, SB and BEQ.
- Drives the datapath mux selects, write enables and ULAControl state by state.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter InstRet.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
OP  input  7  opcode from the instruction register
Funct3  input  3  funct3 from the instruction register
Funct7  input  7  funct7 from the instruction register
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current access this cycle
MemReq  output  1  memory access requested
AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
MemWrite  output  1  memory write strobe
IRWrite  output  1  load instruction register and OldPC
PCWrite  output  1  load PC from the Result bus
RegWrite  output  1  register file write
ResultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU result
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  output  2  00 rs2, 01 immediate, 10 constant 4
ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type
ULAControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
InstRet  output  CNT_W  retired-instruction count
Illegal  output  1  illegal instruction flag (see Optional Feature)

Behaviour:
- Moore FSM with a registered state. All outputs are decoded combinationally from the state, plus MemReady, Zero and the instruction fields where noted.
- Any output not listed for a state is driven 0. No X is ever driven.
- Reset (rst_n low, asynchronous):
  - state = FETCH, InstRet = 0, Illegal = 0.
  - PCWrite, IRWrite, RegWrite, MemWrite and MemReq are forced 0 while rst_n is low.
  - Reset mid-instruction abandons the instruction; the first fetch starts on the first clk edge after release.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ULAControl=000, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 goes to DECODE; otherwise hold.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add. This precomputes the branch target into ALUOut.
  - ImmSrc = 01 for OP 0100011, 10 for OP 1100011, else 00.
  - OP 0000011 or 0100011 with Funct3=000 goes to MEMADR.
  - OP 0110011 with a supported {Funct3,Funct7} pair goes to EXECUTER.
  - OP 0010011 with Funct3=000 goes to EXECUTEI.
  - OP 1100011 with Funct3=000 goes to BRANCH.
  - Anything else is illegal.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add, ImmSrc as in DECODE.
  - Goes to MEMREAD for OP 0000011, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH. Retires the instruction.
- MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=MemReady. Waits for MemReady, then FETCH. Retires the instruction.
- EXECUTER:
  - ALUSrcA=10, ALUSrcB=00.
  - ULAControl from {Funct3,Funct7}: 000/0000000 add, 000/0100000 sub, 111/0000000 and, 110/0000000 or, 010/0000000 slt.
  - Then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH. Retires the instruction.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero.
  - Then FETCH. Retires the instruction whether or not the branch is taken.
- Latency:
  - Taken from FETCH entry to the next FETCH entry, with MemReady=1 every cycle. Fetch is 1 cycle, so the total is 1 plus the cycles after it.
  - BEQ: 3 cycles.
  - R-type and ADDI: 4 cycles.
  - SB: 4 cycles.
  - LB: 5 cycles.
  - Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- InstRet:
  - Increments by 1 on the clk edge that leaves MEMWB, MEMWRITE (with MemReady=1), ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W.
- MemReady is sampled only in memory states. MemReady=1 in any other state is ignored.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - An illegal decode goes to TRAP.
  - TRAP drives all enables 0, sets Illegal=1 and holds until reset.
  - InstRet does not increment.
- Undefined:
  - An illegal decode returns directly to FETCH as a NOP, with no writes and no InstRet increment.
  - The PC has already advanced by 4.
  - TRAP is not built and Illegal is tied to 0.

Test Plan:
- Reset:
  - Drive rst_n low mid-EXECUTER, with MemReady=1.
  - Expect all enables 0 immediately, InstRet=0, state FETCH after release.
- ADD:
  - OP=0110011, F3=000, F7=0000000, MemReady=1.
  - Expect states FETCH, DECODE, EXECUTER, ALUWB.
  - Expect ULAControl=000 in EXECUTER, RegWrite=1 only in ALUWB, InstRet 0→1.
- LB with stall:
  - OP=0000011, MemReady=0 for 2 cycles in MEMREAD.
  - Expect MemReq=1 and AdrSrc=1 held for 3 cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
  - Expect 7 cycles in total.
- SB:
  - OP=0100011.
  - Expect ImmSrc=01 in DECODE and MEMADR, and MemWrite=1 for exactly 1 cycle when MemReady=1.
  - Expect RegWrite never asserted.
- BEQ:
  - OP=1100011, Zero=1, then repeat with Zero=0.
  - Expect PCWrite=1 in BRANCH only when Zero=1 and ULAControl=001.
  - Expect InstRet +1 in both cases.
- Illegal:
  - OP=1111111 with ILLEGAL_TRAP_EN defined: expect Illegal=1 and FSM stuck with no enables until rst_n is pulsed.
  - Without the macro: expect return to FETCH and InstRet unchanged.
